// File: rtl/gp_in_pkg.sv
// Shared helpers for the board-input conditioner: sizing of the per-channel
// debounce counter.
package gp_in_pkg;

  // Counter must hold 0..n-1 and never collapse to zero width.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/gp_in_chan.sv
// One conditioned input channel: polarity, synchroniser, debounce, edge pulses
// and a sticky, enable-gated status bit.
module gp_in_chan
  import gp_in_pkg::*;
#(
  parameter int SyncStages     = 2,
  parameter int DebounceCycles = 50000,
  parameter bit Invert         = 1'b0
) (
  input  logic clk_sys_i,
  input  logic rst_sys_ni,
  input  logic raw_i,
  input  logic rise_en_i,
  input  logic fall_en_i,
  input  logic status_clr_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o,
  output logic status_o
);

  localparam int CntW = cnt_width(DebounceCycles);
  localparam logic [CntW-1:0] CntMax = CntW'(DebounceCycles - 1);

  logic [SyncStages-1:0] sync_p;
  logic                  synced;
  logic                  stable_q;
  logic [CntW-1:0]       cnt_q;
  logic                  rise_q;
  logic                  fall_q;
  logic                  status_q;
  logic                  accept;
  logic                  set_next;
  logic                  pulse_now;

  assign synced    = sync_p[SyncStages-1];
  assign accept    = (synced != stable_q) && (cnt_q == CntMax);
  assign set_next  = accept && ((synced && rise_en_i) || (!synced && fall_en_i));
  // An enabled pulse on show this cycle also overrides a clear strobe, so a
  // clear coinciding with the event never loses it.
  assign pulse_now = (rise_q && rise_en_i) || (fall_q && fall_en_i);

  always_ff @(posedge clk_sys_i) begin
    if (!rst_sys_ni) begin
      sync_p   <= '0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      status_q <= 1'b0;
    end else begin
      sync_p <= {sync_p[SyncStages-2:0], raw_i ^ Invert};
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      if (synced == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CntMax) begin
        stable_q <= synced;
        cnt_q    <= '0;
        rise_q   <= synced;
        fall_q   <= !synced;
      end else begin
        cnt_q <= cnt_q + CntW'(1);
      end
      if (set_next) begin
        status_q <= 1'b1;
      end else if (status_clr_i && !pulse_now) begin
        status_q <= 1'b0;
      end
    end
  end

  assign level_o  = stable_q;
  assign rise_o   = rise_q;
  assign fall_o   = fall_q;
  assign status_o = status_q;

endmodule

// File: rtl/gp_in_conditioner.sv
// Board-input conditioner: NumChannels independent debounced inputs whose
// sticky edge status is ORed into a single interrupt.
module gp_in_conditioner
  import gp_in_pkg::*;
#(
  parameter int                     NumChannels    = 5,
  parameter int                     SyncStages     = 2,
  parameter int                     DebounceCycles = 50000,
  parameter logic [NumChannels-1:0] InvertMask     = '0
) (
  input  logic                   clk_sys_i,
  input  logic                   rst_sys_ni,
  input  logic [NumChannels-1:0] gp_raw_i,
  input  logic [NumChannels-1:0] rise_en_i,
  input  logic [NumChannels-1:0] fall_en_i,
  input  logic [NumChannels-1:0] status_clr_i,
  output logic [NumChannels-1:0] gp_o,
  output logic [NumChannels-1:0] rise_o,
  output logic [NumChannels-1:0] fall_o,
  output logic [NumChannels-1:0] status_o,
  output logic                   irq_o
);

  for (genvar i = 0; i < NumChannels; i++) begin : g_chan
    gp_in_chan #(
      .SyncStages    (SyncStages),
      .DebounceCycles(DebounceCycles),
      .Invert        (InvertMask[i])
    ) u_chan (
      .clk_sys_i   (clk_sys_i),
      .rst_sys_ni  (rst_sys_ni),
      .raw_i       (gp_raw_i[i]),
      .rise_en_i   (rise_en_i[i]),
      .fall_en_i   (fall_en_i[i]),
      .status_clr_i(status_clr_i[i]),
      .level_o     (gp_o[i]),
      .rise_o      (rise_o[i]),
      .fall_o      (fall_o[i]),
      .status_o    (status_o[i])
    );
  end

  assign irq_o = |status_o;

endmodule

// File: tb/tb_gp_in_conditioner.sv
// Directed bench for gp_in_conditioner with SyncStages=2, DebounceCycles=4,
// channel 1 inverted.
module tb_gp_in_conditioner;

  logic       clk_sys_i = 1'b0;
  logic       rst_sys_ni;
  logic [4:0] gp_raw_i;
  logic [4:0] rise_en_i;
  logic [4:0] fall_en_i;
  logic [4:0] status_clr_i;
  logic [4:0] gp_o;
  logic [4:0] rise_o;
  logic [4:0] fall_o;
  logic [4:0] status_o;
  logic       irq_o;

  int checks = 0;
  int errors = 0;

  gp_in_conditioner #(
    .NumChannels   (5),
    .SyncStages    (2),
    .DebounceCycles(4),
    .InvertMask    (5'b00010)
  ) dut (
    .clk_sys_i   (clk_sys_i),
    .rst_sys_ni  (rst_sys_ni),
    .gp_raw_i    (gp_raw_i),
    .rise_en_i   (rise_en_i),
    .fall_en_i   (fall_en_i),
    .status_clr_i(status_clr_i),
    .gp_o        (gp_o),
    .rise_o      (rise_o),
    .fall_o      (fall_o),
    .status_o    (status_o),
    .irq_o       (irq_o)
  );

  always #5 clk_sys_i = ~clk_sys_i;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk_sys_i);
      #1;
    end
  endtask

  task automatic check_all(input string tag, input logic [4:0] g, input logic [4:0] r,
                           input logic [4:0] f, input logic [4:0] s);
    check_val({tag, ".gp"}, 32'(gp_o), 32'(g));
    check_val({tag, ".rise"}, 32'(rise_o), 32'(r));
    check_val({tag, ".fall"}, 32'(fall_o), 32'(f));
    check_val({tag, ".status"}, 32'(status_o), 32'(s));
    check_val({tag, ".irq"}, 32'(irq_o), 32'(|s));
  endtask

  task automatic clear_status();
    status_clr_i = 5'b11111;
    step(1);
    status_clr_i = 5'b00000;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_sys_ni   = 1'b0;
    gp_raw_i     = 5'b00010;
    rise_en_i    = 5'b00000;
    fall_en_i    = 5'b00000;
    status_clr_i = 5'b00000;
    #2;
    step(3);
    check_all("reset", 5'b00000, 5'b00000, 5'b00000, 5'b00000);
    rst_sys_ni = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step(1);
      check_val("idle", {gp_o, rise_o, fall_o, status_o, irq_o}, 32'h0);
    end

    // Rise on ch0, accepted on edge 6 with status and irq.
    rise_en_i = 5'b11111;
    fall_en_i = 5'b11111;
    gp_raw_i  = 5'b00011;
    step(5);
    check_all("rise0_e5", 5'b00000, 5'b00000, 5'b00000, 5'b00000);
    step(1);
    check_all("rise0_e6", 5'b00001, 5'b00001, 5'b00000, 5'b00001);
    step(1);
    check_all("rise0_e7", 5'b00001, 5'b00000, 5'b00000, 5'b00001);

    // Status clear, then a fall, then a rise coinciding with clear.
    status_clr_i = 5'b00001;
    step(1);
    status_clr_i = 5'b00000;
    check_all("clr0", 5'b00001, 5'b00000, 5'b00000, 5'b00000);
    gp_raw_i = 5'b00010;
    step(5);
    check_val("fall0_e5.gp", 32'(gp_o), 32'h01);
    step(1);
    check_all("fall0_e6", 5'b00000, 5'b00000, 5'b00001, 5'b00001);
    step(1);
    clear_status();
    check_val("clr0b.status", 32'(status_o), 32'h00);
    gp_raw_i = 5'b00011;
    step(5);
    check_all("rise0b_e5", 5'b00000, 5'b00000, 5'b00000, 5'b00000);
    status_clr_i = 5'b00001;
    step(1);
    check_all("rise0b_e6", 5'b00001, 5'b00001, 5'b00000, 5'b00001);
    step(1);
    check_val("setwins.status", 32'(status_o), 32'h01);
    status_clr_i = 5'b00000;
    step(1);
    check_all("setwins_after", 5'b00001, 5'b00000, 5'b00000, 5'b00001);
    clear_status();

    // Glitch on ch2 (3 cycles) rejected, 5-cycle pulse accepted.
    gp_raw_i = 5'b00111;
    step(3);
    gp_raw_i = 5'b00011;
    for (int c = 0; c < 10; c++) begin
      step(1);
      check_val("glitch", {gp_o, rise_o, status_o}, {5'b00001, 5'b00000, 5'b00000});
    end
    gp_raw_i = 5'b00111;
    step(5);
    check_val("pulse2_e5.gp", 32'(gp_o), 32'h01);
    gp_raw_i = 5'b00011;
    step(1);
    check_all("pulse2_e6", 5'b00101, 5'b00100, 5'b00000, 5'b00100);
    step(5);
    check_all("pulse2_fall", 5'b00001, 5'b00000, 5'b00100, 5'b00100);
    step(1);
    clear_status();

    // Inverted ch1: raw low means post-inversion high.
    gp_raw_i = 5'b00001;
    step(5);
    check_val("inv1_e5.gp", 32'(gp_o), 32'h01);
    step(1);
    check_all("inv1_rise", 5'b00011, 5'b00010, 5'b00000, 5'b00010);
    step(1);
    clear_status();
    fall_en_i = 5'b11101;
    gp_raw_i  = 5'b00011;
    step(5);
    check_val("inv1_e5b.gp", 32'(gp_o), 32'h03);
    step(1);
    check_all("inv1_fall", 5'b00001, 5'b00000, 5'b00010, 5'b00000);
    step(1);
    check_all("inv1_after", 5'b00001, 5'b00000, 5'b00000, 5'b00000);

    // Reset mid-debounce on ch3; ch0 held high through reset also rises.
    gp_raw_i = 5'b01011;
    for (int c = 0; c < 3; c++) begin
      step(1);
      check_val("mid3.rise", 32'(rise_o), 32'h00);
    end
    rst_sys_ni = 1'b0;
    step(1);
    check_all("mid_reset", 5'b00000, 5'b00000, 5'b00000, 5'b00000);
    rst_sys_ni = 1'b1;
    step(5);
    check_all("rel_e5", 5'b00000, 5'b00000, 5'b00000, 5'b00000);
    step(1);
    check_all("rel_e6", 5'b01001, 5'b01001, 5'b00000, 5'b01001);
    step(1);
    check_all("rel_e7", 5'b01001, 5'b00000, 5'b00000, 5'b01001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
